mem_access_ctrl: RTL and testbench

//   Load/store sequencer between the core's execute stage and the 8-bit x 256 data memory.

---
 rtl/mem_access_ctrl_pkg.sv | 26 ++
 rtl/mem_access_ctrl_if.sv | 25 ++
 rtl/mem_access_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared widths, state encoding and byte-extension helper for the load/store sequencer.
package mem_access_ctrl_pkg;

  localparam int unsigned MEM_AW = 8;
  localparam int unsigned MEM_DW = 8;
  localparam int unsigned RSP_W  = 2 * MEM_DW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } mac_state_t;

  // Plain vector encodings of the states, used by the state register
  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_LO   = 2'(LO);
  localparam logic [1:0] ST_HI   = 2'(HI);
  localparam logic [1:0] ST_RESP = 2'(RESP);

  // Upper byte of a byte-load result: sign copy or zero
  function automatic logic [MEM_DW-1:0] ext_byte(input logic [MEM_DW-1:0] b, input logic sext);
    return (sext && b[MEM_DW-1]) ? {MEM_DW{1'b1}} : {MEM_DW{1'b0}};
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response bus of the load/store sequencer.
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_word;
  logic [MEM_AW-1:0] req_addr;
  logic [RSP_W-1:0]  req_wdata;
  logic              rsp_valid;
  logic [RSP_W-1:0]  rsp_rdata;

  // Execute stage issuing requests
  modport master (
    output req_valid, req_we, req_word, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // Sequencer serving requests
  modport slave (
    input  req_valid, req_we, req_word, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: splits 16-bit accesses into two little-endian byte accesses
// on an 8-bit memory with combinational read, one response per request.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter bit SEXT_BYTE = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_access_ctrl_if.slave     core,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [MEM_DW-1:0]    mem_din,
  output logic                 mem_wr_en,
  input  logic [MEM_DW-1:0]    mem_dout
);

  logic [1:0]        state_q,     state_d;
  logic              we_q,        we_d;
  logic              word_q,      word_d;
  logic [MEM_AW-1:0] addr_q,      addr_d;
  logic [RSP_W-1:0]  wdata_q,     wdata_d;
  logic [MEM_DW-1:0] rd_lo_q,     rd_lo_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [RSP_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [MEM_AW-1:0] mem_addr_q,  mem_addr_d;
  logic [MEM_DW-1:0] mem_din_q,   mem_din_d;
  logic              mem_wr_en_q, mem_wr_en_d;

  // Next state and next registered outputs; memory-side outputs are set up one state ahead
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    word_d      = word_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_lo_d     = rd_lo_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_wr_en_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (core.req_valid) begin
          state_d     = ST_LO;
          we_d        = core.req_we;
          word_d      = core.req_word;
          addr_d      = core.req_addr;
          wdata_d     = core.req_wdata;
          mem_addr_d  = core.req_addr;
          mem_din_d   = core.req_wdata[MEM_DW-1:0];
          mem_wr_en_d = core.req_we;
        end
      end
      ST_LO: begin
        rd_lo_d = mem_dout;
        if (word_q) begin
          state_d     = ST_HI;
          mem_addr_d  = addr_q + MEM_AW'(1);
          mem_din_d   = wdata_q[RSP_W-1:MEM_DW];
          mem_wr_en_d = we_q;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : {ext_byte(mem_dout, SEXT_BYTE), mem_dout};
        end
      end
      ST_HI: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? '0 : {mem_dout, rd_lo_q};
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      word_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_lo_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_wr_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_lo_q     <= rd_lo_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_wr_en_q <= mem_wr_en_d;
    end
  end

  assign core.req_ready = req_ready_q;
  assign core.rsp_valid = rsp_valid_q;
  assign core.rsp_rdata = rsp_rdata_q;
  assign mem_addr       = mem_addr_q;
  assign mem_din        = mem_din_q;
  // Reset arriving mid-store must block the write at that same edge, so gate the strobe directly
  assign mem_wr_en      = mem_wr_en_q & ~reset;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: zero- and sign-extending instances driven in lockstep against a byte-array model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  always #5 clk = ~clk;

  mem_access_ctrl_if core0();
  mem_access_ctrl_if core1();

  logic [7:0] maddr0, mdin0, mdout0, maddr1, mdin1, mdout1;
  logic       mwe0, mwe1;

  mem_access_ctrl #(.SEXT_BYTE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .core(core0),
    .mem_addr(maddr0), .mem_din(mdin0), .mem_wr_en(mwe0), .mem_dout(mdout0)
  );
  mem_access_ctrl #(.SEXT_BYTE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .core(core1),
    .mem_addr(maddr1), .mem_din(mdin1), .mem_wr_en(mwe1), .mem_dout(mdout1)
  );

  logic [7:0] seed_mem [256];
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] ref_mem [256];

  assign mdout0 = mem0[maddr0];
  assign mdout1 = mem1[maddr1];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= seed_mem[i];
        mem1[i] <= seed_mem[i];
      end
    end else begin
      if (mwe0) mem0[maddr0] <= mdin0;
      if (mwe1) mem1[maddr1] <= mdin1;
    end
  end

  int unsigned wr0 = 0, wr1 = 0, rv0 = 0, rv1 = 0;
  always @(posedge clk) begin
    if (mwe0) wr0 <= wr0 + 1;
    if (mwe1) wr1 <= wr1 + 1;
    if (core0.rsp_valid) rv0 <= rv0 + 1;
    if (core1.rsp_valid) rv1 <= rv1 + 1;
  end

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input logic v, input logic we, input logic word,
                         input logic [7:0] a, input logic [15:0] d);
    core0.req_valid = v; core0.req_we = we; core0.req_word = word;
    core0.req_addr  = a; core0.req_wdata = d;
    core1.req_valid = v; core1.req_we = we; core1.req_word = word;
    core1.req_addr  = a; core1.req_wdata = d;
  endtask

  // One complete request, entered and left at a negedge with both controllers idle
  task automatic do_req(input logic we, input logic word, input logic [7:0] a, input logic [15:0] d);
    int unsigned w0s, w1s, r0s, r1s, nwr, lat;
    logic [7:0]  a1, lo, hi;
    logic [15:0] exp0, exp1;
    bit          seen;
    a1 = a + 8'd1;
    w0s = wr0; w1s = wr1; r0s = rv0; r1s = rv1;
    lat  = word ? 3 : 2;
    nwr  = we ? (word ? 2 : 1) : 0;
    seen = 1'b0;
    if (we) begin
      ref_mem[a] = d[7:0];
      if (word) ref_mem[a1] = d[15:8];
      exp0 = 16'h0000;
      exp1 = 16'h0000;
    end else begin
      lo = ref_mem[a];
      hi = ref_mem[a1];
      exp0 = word ? {hi, lo} : {8'h00, lo};
      exp1 = word ? {hi, lo} : (lo >= 8'h80 ? {8'hFF, lo} : {8'h00, lo});
    end

    chk("ready_idle", 32'(core0.req_ready), 1);
    set_req(1'b1, we, word, a, d);
    @(posedge clk);
    for (int k = 1; k <= 6 && !seen; k++) begin
      @(negedge clk);
      if (core0.rsp_valid) begin
        seen = 1'b1;
        chk("latency", 32'(k), 32'(lat));
        chk("rsp_valid_sext", 32'(core1.rsp_valid), 1);
        chk("rdata_zext", 32'(core0.rsp_rdata), 32'(exp0));
        chk("rdata_sext", 32'(core1.rsp_rdata), 32'(exp1));
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
      end else begin
        chk("ready_busy", 32'(core0.req_ready), 0);
      end
    end
    if (!seen) begin
      chk("rsp_timeout", 0, 1);
      set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    end
    @(negedge clk);
    chk("rsp_one_pulse", 32'(core0.rsp_valid), 0);
    chk("ready_after", 32'(core0.req_ready), 1);
    chk("wr_pulses", wr0 - w0s, nwr);
    chk("wr_pulses_sext", wr1 - w1s, nwr);
    chk("rsp_count", (rv0 - r0s) + (rv1 - r1s), 2);
    chk("mem_lo", 32'(mem0[a]), 32'(ref_mem[a]));
    chk("mem_hi", 32'(mem0[a1]), 32'(ref_mem[a1]));
    chk("mem_lo_sext", 32'(mem1[a]), 32'(ref_mem[a]));
  endtask

  // Word store to 0x40 aborted by reset while its high byte is being written
  task automatic abort_test();
    int unsigned w0s, r0s;
    w0s = wr0; r0s = rv0;
    ref_mem[8'h40] = 8'hD2;
    set_req(1'b1, 1'b1, 1'b1, 8'h40, 16'hC3D2);
    @(posedge clk);
    @(negedge clk);
    chk("abort_lo_wren", 32'(mwe0), 1);
    @(negedge clk);
    chk("abort_hi_addr", 32'(maddr0), 32'h41);
    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    chk("wren_in_reset", 32'(mwe0), 0);
    @(negedge clk);
    chk("abort_no_rsp", 32'(core0.rsp_valid), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(core0.req_ready), 1);
    chk("abort_rsp_count", rv0 - r0s, 0);
    chk("abort_wr_pulses", wr0 - w0s, 1);
    chk("abort_mem40", 32'(mem0[8'h40]), 32'(ref_mem[8'h40]));
    chk("abort_mem41", 32'(mem0[8'h41]), 32'(ref_mem[8'h41]));
  endtask

  initial begin
    logic [7:0] ra;
    for (int i = 0; i < 256; i++) begin
      seed_mem[i] = 8'($urandom);
      ref_mem[i]  = seed_mem[i];
    end
    reset = 1'b1;
    mem_init = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_init = 1'b0;
    chk("rst_ready", 32'(core0.req_ready), 1);
    chk("rst_rsp_valid", 32'(core0.rsp_valid), 0);
    chk("rst_rdata", 32'(core0.rsp_rdata), 0);
    chk("rst_wren", 32'(mwe0), 0);
    chk("rst_addr", 32'(maddr0), 0);
    chk("rst_din", 32'(mdin0), 0);

    do_req(1'b1, 1'b0, 8'h10, 16'h00A5);
    do_req(1'b0, 1'b0, 8'h10, 16'h0000);
    do_req(1'b1, 1'b1, 8'h20, 16'hBEEF);
    do_req(1'b0, 1'b1, 8'h20, 16'h0000);
    chk("word_load_beef", {ref_mem[8'h21], ref_mem[8'h20]}, 32'hBEEF);
    do_req(1'b1, 1'b1, 8'hFF, 16'h1234);
    chk("wrap_mem00", 32'(mem0[8'h00]), 32'h12);
    do_req(1'b0, 1'b1, 8'hFF, 16'h0000);
    do_req(1'b1, 1'b0, 8'h30, 16'h5580);
    do_req(1'b0, 1'b0, 8'h30, 16'h0000);
    abort_test();

    for (int n = 0; n < 60; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      do_req(1'($urandom), 1'($urandom), ra, 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
